// File: rtl/async_mem_pkg.sv
// Shared definitions for the phase-multiplexed memory and its request-side client.
// The memory wrapper uses the same phase constants, so both sides agree on which
// phase of the 2-bit counter reads and which phase writes.
package async_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_CAP  = 3'd2,
    WR_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [1:0] PHASE_READ  = 2'b00;
  localparam logic [1:0] PHASE_WRITE = 2'b10;

endpackage

// File: rtl/async_mem_client.sv
// Request-side controller for the phase-multiplexed memory.
// Takes one read/write request at a time, waits for the matching memory phase,
// and returns one response per request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new request (o_req_ready=1)
// RD_WAIT | read address on the bus, waiting for the read phase
// RD_CAP  | memory data valid this cycle, captured into response reg
// WR_WAIT | write address/data on the bus, strobe fires in write phase
// RESP    | response presented until consumed
//
// Ports:
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_counter             free-running memory phase from the clock generator
//   i_req_*, o_req_ready  request channel (valid/ready)
//   o_rsp_*, i_rsp_ready  response channel (valid/ready)
//   o_mem_*, i_mem_rdata  phased memory port
module async_mem_client
  import async_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_counter,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_wdata
);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_mem_write;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= i_req_write ? WR_WAIT : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (i_counter == PHASE_READ) r_state <= RD_CAP;
        end
        RD_CAP: begin
          // memory returns data the cycle after its read phase
          r_rdata     <= i_mem_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        WR_WAIT: begin
          if (i_counter == PHASE_WRITE) begin
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // pop returns to IDLE; the next accept can only happen a cycle later
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Strobe is decoded from state and phase so it lines up with the memory's
  // write phase; reset masks it so a write in flight never lands.
  assign w_mem_write = (r_state == WR_WAIT) && (i_counter == PHASE_WRITE) && !i_rst;

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_mem_raddr = r_addr;
  assign o_mem_waddr = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_write = w_mem_write;

endmodule

// File: tb/tb_async_mem_client.sv
// Directed + random bench for async_mem_client with a phased memory model.
module tb_async_mem_client;
  import async_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  counter = 2'd0;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [7:0]  mem_waddr;
  logic        mem_write;
  logic [31:0] mem_wdata;

  logic        init_mem;
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  async_mem_client #(.ADDR_W(8), .DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_counter   (counter),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_mem_raddr (mem_raddr),
    .i_mem_rdata (mem_rdata),
    .o_mem_waddr (mem_waddr),
    .o_mem_write (mem_write),
    .o_mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) counter <= counter + 2'd1;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h12) return 32'hDEADBEEF;
    return {a, a, a, a} ^ 32'h5A00_0000;
  endfunction

  // Phased memory: reads sample the address in phase 00 and present data the
  // next cycle; writes land when the strobe is high.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_write) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (counter == PHASE_READ) mem_rdata <= mem[mem_raddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [1:0] k);
    for (int i = 0; i < 4 && counter != k; i++) step();
  endtask

  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input int hold, output int lat);
    logic [1:0]  k;
    logic [1:0]  d;
    int          exp_lat;
    int          wr_cnt;
    logic        phase_bad, ready_hi, addr_bad, bp_bad;
    logic [31:0] exp_rdata;
    logic [31:0] held;
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    k         = counter;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    step();
    // scrambled inputs after the accept edge must be ignored
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~addr;
    req_wdata = ~wd;
    lat = 1; wr_cnt = 0;
    phase_bad = 1'b0; ready_hi = 1'b0; addr_bad = 1'b0; bp_bad = 1'b0;
    while (lat < 12) begin
      if (mem_write) begin
        wr_cnt++;
        if (counter != PHASE_WRITE) phase_bad = 1'b1;
      end
      if (req_ready) ready_hi = 1'b1;
      if (mem_raddr !== addr || mem_waddr !== addr) addr_bad = 1'b1;
      if (wr && mem_wdata !== wd) addr_bad = 1'b1;
      if (rsp_valid) break;
      step();
      lat++;
    end
    if (wr) begin
      d = 2'd2 - (k + 2'd1);
      exp_lat = int'(d) + 2;
      exp_rdata = 32'd0;
    end else begin
      d = 2'd0 - (k + 2'd1);
      exp_lat = int'(d) + 3;
      exp_rdata = ref_mem[addr];
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("mem_write_pulses", 32'(wr_cnt), wr ? 32'd1 : 32'd0);
    chk("mem_write_phase_bad", {31'd0, phase_bad}, 32'd0);
    chk("req_ready_while_busy", {31'd0, ready_hi}, 32'd0);
    chk("mem_bus_unstable", {31'd0, addr_bad}, 32'd0);
    if (wr) ref_mem[addr] = wd;
    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      step();
      if (!rsp_valid || rsp_rdata !== held || req_ready || mem_write) bp_bad = 1'b1;
    end
    chk("backpressure_bad", {31'd0, bp_bad}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_pop", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_after_pop", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    logic wr_seen, rsp_seen;
    rst = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    step(); step(); step();

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_raddr", {24'd0, mem_raddr}, 32'd0);
    chk("rst_mem_waddr", {24'd0, mem_waddr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0; init_mem = 1'b0;
    step();
    chk("req_ready_after_release", {31'd0, req_ready}, 32'd1);

    // read at phase 3: minimum read latency
    wait_phase(2'd3);
    do_req(1'b0, 8'h12, 32'h0, 0, lat);
    chk("rd_k3_lat", 32'(lat), 32'd3);

    // read at phase 0: maximum read latency
    wait_phase(2'd0);
    do_req(1'b0, 8'h40, 32'h0, 0, lat);
    chk("rd_k0_lat", 32'(lat), 32'd6);

    // write at phase 1: minimum write latency, then read it back
    wait_phase(2'd1);
    do_req(1'b1, 8'h05, 32'hA5A5A5A5, 0, lat);
    chk("wr_k1_lat", 32'(lat), 32'd2);
    do_req(1'b0, 8'h05, 32'h0, 0, lat);
    chk("rd_back_05", ref_mem[8'h05], 32'hA5A5A5A5);

    // write at phase 2: maximum write latency
    wait_phase(2'd2);
    do_req(1'b1, 8'h06, 32'h1234_5678, 0, lat);
    chk("wr_k2_lat", 32'(lat), 32'd5);

    // backpressure on a read response
    do_req(1'b0, 8'h12, 32'h0, 10, lat);

    // reset while a write waits, one cycle before its write phase
    wait_phase(2'd0);
    chk("req_ready_before_rst_wr", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 32'h2222_2222;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    wr_seen = mem_write;
    step();
    rst = 1'b0;
    rsp_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_write) wr_seen = 1'b1;
      if (rsp_valid) rsp_seen = 1'b1;
      step();
    end
    chk("rst_mid_mem_write", {31'd0, wr_seen}, 32'd0);
    chk("rst_mid_rsp", {31'd0, rsp_seen}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 8'h33, 32'h0, 0, lat);
    chk("rst_mid_mem_intact", ref_mem[8'h33], init_val(8'h33));

    // random mixed stream
    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 2), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/async_mem_client.md
# async_mem_client

Request-side controller for the phase-multiplexed memory. It accepts one read or write request at a time on a valid/ready interface and drives the memory address, data and write-enable lines so each access lands on the correct phase of the shared 2-bit phase counter. It returns one response per request on a valid/ready interface. It sits between CPU-side logic running on `clk` and the phased memory, and takes `counter` from the same clock generator that feeds the memory.

## Interface
- `ADDR_W`, 8: request and memory address width.
- `DATA_W`, 32: data width.
- `clk` input 1: single clock, same clock that advances `counter`.
- `rst` input 1: synchronous, active-high reset.
- `counter` input 2: free-running memory phase. Memory reads in phase 2'b00 and writes in phase 2'b10. Not affected by `rst`.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when high together with `req_valid`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: access address.
- `req_wdata` input DATA_W: write data.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` output DATA_W: read data; 0 for writes.
- `mem_raddr` output ADDR_W: memory read address.
- `mem_rdata` input DATA_W: memory read data, valid in the cycle after the phase-00 cycle.
- `mem_waddr` output ADDR_W: memory write address.
- `mem_write` output 1: write strobe.
- `mem_wdata` output DATA_W: memory write data.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - RD_WAIT: `mem_raddr` holds the latched address. On the first cycle with `counter`==2'b00, go to RD_CAP.
  - RD_CAP: load `rsp_rdata` from `mem_rdata`, then go to RESP.
  - WR_WAIT: `mem_waddr`/`mem_wdata` hold latched values. `mem_write` = (`counter`==2'b10). On that cycle, go to RESP with `rsp_rdata` := 0.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- On the accept edge, address and data are latched into registers and the state becomes RD_WAIT or WR_WAIT according to `req_write`. `req_*` inputs are ignored after acceptance.
- `req_ready` is high only in IDLE. No accept happens in the same cycle as a response pop, so there is no combinational path from `rsp_ready` to `req_ready`.
- `mem_write` is a pure function of state and `counter`. It is never high outside WR_WAIT, and never more than one cycle per request.
- `mem_raddr` and `mem_waddr` are both driven from one address register and are stable from the cycle after acceptance until RESP.
- A response held in RESP keeps `rsp_rdata` stable indefinitely while `rsp_ready`=0.
- Exactly one response per accepted request, in order. Accesses are serialized, so there are no read/write hazards.

## Timing
- Reset values: state IDLE, `req_ready`=1 from the first cycle after reset release, `rsp_valid`=0, `rsp_rdata`=0, `mem_write`=0, `mem_raddr`/`mem_waddr`/`mem_wdata`=0.
- Reset mid-operation: the in-flight request is dropped with no response. `mem_write` is 0 in the reset cycle.
- Let k = `counter` value in the accept cycle. Latencies are measured from the accept edge to the first cycle with `rsp_valid` high:
  - Read: ((0 − (k+1)) mod 4) + 3 cycles. Minimum 3 (k=3), maximum 6 (k=0).
  - Write: ((2 − (k+1)) mod 4) + 2 cycles. Minimum 2 (k=1), maximum 5 (k=2).
- Counter wrap 2'b11→2'b00 needs no special handling; the phase compares are modulo-4 by width.
- Back-to-back throughput: a new accept is possible in the cycle after the response pop.

## Structure
- Shared package `async_mem_pkg`:
  - State enum: IDLE, RD_WAIT, RD_CAP, WR_WAIT, RESP.
  - Constants `PHASE_READ`=2'b00 and `PHASE_WRITE`=2'b10, which the memory wrapper also uses.
- Single flat module with no sub-module. The FSM and three registers (address, write data, response data) are the whole datapath.

## Test plan
- Read, accept at `counter`=3, addr 0x12, memory preloaded with 0xDEADBEEF: `mem_raddr`=0x12 during the phase-00 cycle; `rsp_valid` 3 cycles after accept with `rsp_rdata`=0xDEADBEEF.
- Read, accept at `counter`=0: `rsp_valid` 6 cycles after accept; `req_ready`=0 throughout.
- Write, accept at `counter`=1, addr 0x05, data 0xA5A5A5A5: `mem_write` high for exactly one cycle, at phase 10; `rsp_valid` 2 cycles after accept with `rsp_rdata`=0. A following read of 0x05 returns 0xA5A5A5A5.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after a read response. `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0, and `mem_write` stays 0.
- Reset asserted in WR_WAIT one cycle before phase 10: `mem_write` never pulses, no response is produced, and `req_ready`=1 after release.
- Random stream of 200 mixed requests with random `rsp_ready`: in-order responses match a reference memory model, and every latency lies within its min/max bounds.
